wb_bram_burst: RTL and testbench

- Parametrised Wishbone B4 (classic + registered-feedback) block-RAM slave; next generation of the team's 32-bit BlockRAM slave.
- Generalised data width and depth; byte enables at any width.
- Adds full incrementing-burst support (linear and wrap-4/8/16 via bte), single-wait-state classic cycles with cyc qualification, and burst-abort handling.
- Sits behind the memory-controller Wishbone interconnect as a zero-wait-state-in-burst scratch/frame memory.

---
 rtl/wb_bram_burst_if.sv | 28 ++
 rtl/wb_bram_burst.sv | 121 ++++++++++++
 tb/tb_wb_bram_burst.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 bus bundle for the burst-capable block-RAM slave.
// Master drives request/write-data/burst-tags; slave returns read data and acknowledges.
interface wb_bram_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 32
) ();
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADR_WIDTH-1:0]    adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_ms;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic [DATA_WIDTH-1:0]   dat_sm;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave: one wait state on the first beat, zero-wait incrementing bursts
// (linear and wrap-4/8/16). Define WB_BRAM_ERR_EN to answer out-of-range accesses with err.
module wb_bram_burst #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADR_WIDTH = 11,
    parameter int ADR_WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_bram_burst_if.slave   wb
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int DEPTH = 1 << MEM_ADR_WIDTH;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;
    typedef logic [MEM_ADR_WIDTH-1:0] idx_t;

    state_t                state_q, state_d;
    idx_t                  cnt_q, cnt_d, rd_idx, adr_idx, cnt_inc, wrap_mask;
    logic                  ack_q, ack_d, err_q, err_d;
    logic                  req, wr_en, oob_first, oob_burst;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  unused_adr;

    assign req        = wb.cyc & wb.stb;
    assign adr_idx    = wb.adr[MEM_ADR_WIDTH+LSB-1:LSB];
    assign unused_adr = ^wb.adr;

    // Wrap bursts only advance the low log2(N) bits; linear advances the whole index.
    always_comb begin
        unique case (wb.bte)
            2'b01:   wrap_mask = idx_t'(3);
            2'b10:   wrap_mask = idx_t'(7);
            2'b11:   wrap_mask = idx_t'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign cnt_inc = (cnt_q & ~wrap_mask) | ((cnt_q + idx_t'(1)) & wrap_mask);

`ifdef WB_BRAM_ERR_EN
    assign oob_first = |wb.adr[ADR_WIDTH-1:MEM_ADR_WIDTH+LSB];
    assign oob_burst = (wb.bte == 2'b00) && (&cnt_q);
`else
    assign oob_first = 1'b0;
    assign oob_burst = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_idx  = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d  = adr_idx;
                    rd_idx = adr_idx;
                    if (oob_first) begin
                        err_d   = 1'b1;
                        state_d = CLASSIC;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = (wb.cti == 3'b010) ? BURST : CLASSIC;
                    end
                end
            end
            // Single acked (or errored) beat, then back to IDLE to re-sample.
            CLASSIC: state_d = IDLE;
            BURST: begin
                if (req && wb.cti == 3'b010) begin
                    if (oob_burst) begin
                        err_d   = 1'b1;
                        state_d = CLASSIC;
                    end else begin
                        ack_d  = 1'b1;
                        cnt_d  = cnt_inc;
                        rd_idx = cnt_inc;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (ack_d)
                dat_q <= mem[rd_idx];
        end
    end

    // Write lands on the acked beat at the bus address; concurrent prefetch sees old data.
    assign wr_en = req & wb.we & ack_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < SEL_W; i++) begin
            if (wr_en && wb.sel[i])
                mem[adr_idx][i*8 +: 8] <= wb.dat_ms[i*8 +: 8];
        end
    end

    assign wb.dat_sm = dat_q;
    assign wb.ack    = ack_q;
    assign wb.err    = err_q;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, byte enables, linear/wrap bursts, abort, reset,
// range boundary and (build-dependent) aliasing versus err.
module tb_wb_bram_burst;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    wb_bram_burst_if #(.DATA_WIDTH(32), .ADR_WIDTH(32)) bus ();

    wb_bram_burst #(
        .DATA_WIDTH   (32),
        .MEM_ADR_WIDTH(11),
        .ADR_WIDTH    (32)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .wb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_req();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        bus.cti = 3'b000;
        bus.bte = 2'b00;
    endtask

    task automatic start_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
        bus.cyc    = 1'b1;
        bus.stb    = 1'b1;
        bus.we     = w;
        bus.adr    = a;
        bus.sel    = s;
        bus.dat_ms = d;
        bus.cti    = c;
        bus.bte    = b;
    endtask

    // One classic access: wait state, single ack, then ack low.
    task automatic wb_classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
        start_req(w, a, s, d, 3'b000, 2'b00);
        chk({tag, "_wait"}, {31'd0, bus.ack}, 32'd0);
        step();
        chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd1);
        if (!w) chk({tag, "_rd"}, bus.dat_sm, exp_rd);
        step();
        chk({tag, "_ack_off"}, {31'd0, bus.ack}, 32'd0);
        drop_req();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.adr = '0;
        bus.sel = '0;
        bus.dat_ms = '0;
        drop_req();
        step();
        step();
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_dat", bus.dat_sm, 32'd0);
        rst_n = 1'b1;
        step();

        // Classic write/read and byte enables on word 4
        wb_classic(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, "cl_wr");
        wb_classic(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, "cl_rd");
        wb_classic(1'b1, 32'h10, 4'b0101, 32'h11223344, 32'h0, "be_wr");
        wb_classic(1'b0, 32'h10, 4'hF, 32'h0, 32'hDE22BE44, "be_rd");

        for (int i = 0; i < 8; i++)
            wb_classic(1'b1, 32'(i * 4), 4'hF, 32'h100 + 32'(i), 32'h0, "preload");

        wb_classic(1'b1, 32'h4, 4'h0, 32'hFFFFFFFF, 32'h0, "sel0_wr");
        wb_classic(1'b0, 32'h4, 4'hF, 32'h0, 32'h101, "sel0_rd");

        // Linear burst from word 2, four beats
        start_req(1'b0, 32'h8, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("lin_wait", {31'd0, bus.ack}, 32'd0);
        step(); chk("lin_b1", bus.dat_sm, 32'h102); chk("lin_a1", {31'd0, bus.ack}, 32'd1);
        step(); chk("lin_b2", bus.dat_sm, 32'h103); chk("lin_a2", {31'd0, bus.ack}, 32'd1);
        step(); chk("lin_b3", bus.dat_sm, 32'h104); chk("lin_a3", {31'd0, bus.ack}, 32'd1);
        step(); chk("lin_b4", bus.dat_sm, 32'h105); chk("lin_a4", {31'd0, bus.ack}, 32'd1);
        bus.cti = 3'b111;
        step(); chk("lin_end", {31'd0, bus.ack}, 32'd0); chk("lin_hold", bus.dat_sm, 32'h105);
        drop_req();
        step();

        // Wrap-4 from word 2: 2,3,0,1
        start_req(1'b0, 32'h8, 4'hF, 32'h0, 3'b010, 2'b01);
        step(); chk("w4_b1", bus.dat_sm, 32'h102);
        step(); chk("w4_b2", bus.dat_sm, 32'h103);
        step(); chk("w4_b3", bus.dat_sm, 32'h100);
        step(); chk("w4_b4", bus.dat_sm, 32'h101); chk("w4_a4", {31'd0, bus.ack}, 32'd1);
        bus.cti = 3'b111;
        step(); chk("w4_end", {31'd0, bus.ack}, 32'd0);
        drop_req();
        step();

        // Abort: drop stb after two beats
        start_req(1'b0, 32'h0, 4'hF, 32'h0, 3'b010, 2'b00);
        step(); chk("ab_b1", bus.dat_sm, 32'h100);
        step(); chk("ab_b2", bus.dat_sm, 32'h101);
        bus.stb = 1'b0;
        step(); chk("ab_ack", {31'd0, bus.ack}, 32'd0); chk("ab_hold", bus.dat_sm, 32'h101);
        drop_req();
        wb_classic(1'b0, 32'h4, 4'hF, 32'h0, 32'h101, "ab_resume");

        // Asynchronous reset mid-burst
        start_req(1'b0, 32'h8, 4'hF, 32'h0, 3'b010, 2'b00);
        step(); chk("mr_b1", bus.dat_sm, 32'h102);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_ack", {31'd0, bus.ack}, 32'd0);
        chk("mr_err", {31'd0, bus.err}, 32'd0);
        chk("mr_dat", bus.dat_sm, 32'd0);
        drop_req();
        step();
        rst_n = 1'b1;
        step();
        chk("mr_idle", {31'd0, bus.ack}, 32'd0);
        wb_classic(1'b0, 32'h8, 4'hF, 32'h0, 32'h102, "mr_mem");

        // Top-of-range boundary: word 2047 then linear advance
        wb_classic(1'b1, 32'h1FFC, 4'hF, 32'h7FF, 32'h0, "top_wr");
        start_req(1'b0, 32'h1FFC, 4'hF, 32'h0, 3'b010, 2'b00);
        step(); chk("top_b1", bus.dat_sm, 32'h7FF);
        step();
`ifdef WB_BRAM_ERR_EN
        chk("top_err", {31'd0, bus.err}, 32'd1);
        chk("top_noack", {31'd0, bus.ack}, 32'd0);
`else
        chk("top_wrap", bus.dat_sm, 32'h100);
        chk("top_ack", {31'd0, bus.ack}, 32'd1);
`endif
        bus.cti = 3'b111;
        step(); chk("top_end", {31'd0, bus.ack | bus.err}, 32'd0);
        drop_req();
        step();

        // Out-of-range address 0x2000: aliases to word 0, or errors
`ifdef WB_BRAM_ERR_EN
        start_req(1'b1, 32'h2000, 4'hF, 32'hCAFEF00D, 3'b000, 2'b00);
        step();
        chk("oor_err", {31'd0, bus.err}, 32'd1);
        chk("oor_ack", {31'd0, bus.ack}, 32'd0);
        step();
        chk("oor_err_off", {31'd0, bus.err}, 32'd0);
        drop_req();
        wb_classic(1'b0, 32'h0, 4'hF, 32'h0, 32'h100, "oor_mem");
`else
        wb_classic(1'b1, 32'h2000, 4'hF, 32'hCAFEF00D, 32'h0, "alias_wr");
        wb_classic(1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, "alias_rd");
        chk("alias_err", {31'd0, bus.err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
